ts_pkt_rr_sched: RTL
====================

Name: ts_pkt_rr_sched

Overview:
- Packet-level round-robin scheduler that shares a single 33-bit TS output stream among NCH channel packet buffers.
- Each channel raises a request when it holds one complete TS packet; the scheduler grants one channel at a time for exactly PKT_WORDS words.
- It forwards the granted channel's words, registered, to the output. It sits between the per-channel CSA/buffer stage and the downstream output FIFO.
- Word format: bit 32 = start-of-packet flag; bits 31:0 = packet data, big-endian.

Parameters:
- NCH, 32, number of requesting channels.
- DW, 33, word width (SOP flag + 32 data bits).
- PKT_WORDS, 47, words per TS packet (188 bytes / 4).
- TIMEOUT, 256, maximum cycles without a word while granted before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- ch_req  in  NCH  bit i = channel i holds one full packet.
- ch_din  in  NCH*DW  packed channel words; channel i occupies bits [i*DW +: DW].
- ch_din_en  in  NCH  bit i = ch_din word i valid this cycle.
- out_afull  in  1  downstream almost-full; blocks new grants only.
- ch_grant  out  NCH  one-hot read grant to channel buffers.
- dout  out  DW  scheduled output word.
- dout_en  out  1  dout valid.
- cur_ch  out  5 (clog2 NCH)  index of the granted channel.
- to_err  out  1  one-cycle pulse on timeout abort.
- sop_err  out  1  one-cycle pulse when a packet's first word lacks the SOP flag.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; FSM to IDLE; word counter 0; round-robin pointer last = NCH-1, so channel 0 has top priority first. Reset mid-packet abandons the packet with no error pulse.
- FSM states: IDLE, XFER.
- IDLE -> XFER when (ch_req != 0) and out_afull = 0.
  - Winner = first set ch_req bit searching last+1, last+2, ... modulo NCH.
  - At that edge: ch_grant set one-hot, cur_ch = winner, last = winner, counter = 0.
  - Grant therefore appears 1 cycle after the qualifying request.
- XFER: only ch_din_en[cur_ch] is accepted; enables from other channels are ignored.
  - Each accepted word: dout <= ch_din[cur_ch], dout_en <= 1 on the next cycle (latency 1); counter increments.
  - When the PKT_WORDS-th word is accepted: ch_grant cleared at that same edge, FSM -> IDLE. At least 1 idle cycle separates consecutive grants.
  - Words arriving after the grant has dropped are ignored.
- SOP check: if the first accepted word of a grant has bit 32 = 0:
  - word is not forwarded (dout_en stays 0);
  - sop_err pulses 1 cycle;
  - grant dropped, FSM -> IDLE, last keeps the faulty channel.
  - Bit 32 on any later word is passed through unchecked.
- Timeout: an idle counter resets on every accepted word and increments on every XFER cycle without one.
  - On reaching TIMEOUT: grant dropped, FSM -> IDLE, to_err pulses 1 cycle.
  - Words already forwarded are not retracted.
- out_afull is sampled only in IDLE. A packet in progress always completes.
- dout holds its last value when dout_en = 0.
- Counter width is clog2(PKT_WORDS+1) bits; no wrap, because the grant ends at PKT_WORDS.

Optional Feature:
- Macro: TS_NULL_FILL_EN.
- Defined: when IDLE with ch_req = 0 and out_afull = 0 for 16 consecutive cycles, the scheduler emits one null packet.
  - Word 0 = {1'b1, 32'h471FFF10}; words 1..46 = {1'b0, 32'hFFFFFFFF}; one word per cycle.
  - Grant stays 0 and cur_ch is unchanged during the null packet.
  - Requests wait until the null packet completes.
- Undefined: the output stays silent when idle; no null-fill logic is present.

Test Plan:
- Reset, then ch_req = 32'h1 with a 47-word packet (word 0 SOP = 1) -> ch_grant = 32'h1 one cycle later; 47 dout_en pulses, each 1 cycle after its ch_din_en; ch_grant = 0 after the 47th word; no errors.
- last = 3, then ch_req = bits {0,3,5} held -> grant order 5, 0, 3; each grant carries exactly 47 words.
- out_afull = 1 with ch_req = 32'h4 -> ch_grant stays 0; release out_afull -> ch_grant = 32'h4 one cycle later. Asserting out_afull mid-packet does not stop the transfer.
- Granted channel sends 10 words then stops -> to_err pulses 256 cycles after the 10th word; grant drops; exactly 10 dout_en pulses.
- First word of a grant = {1'b0, 32'h12345678} -> sop_err pulses; dout_en stays 0; FSM returns to IDLE; next grant goes to the next requester.
- With TS_NULL_FILL_EN defined and no requests -> after 16 idle cycles dout = {1'b1, 32'h471FFF10}, followed by 46 words of 32'hFFFFFFFF. Without the macro, dout_en stays 0.

Source files
------------

// File: rtl/ts_pkt_rr_sched.sv
// Packet-level round-robin scheduler: grants one channel at a time for a full
// TS packet and forwards its words, registered, onto a shared output stream.
// Optional null-packet fill when idle is enabled by defining TS_NULL_FILL_EN.
module ts_pkt_rr_sched #(
  parameter int unsigned NCH       = 32,
  parameter int unsigned DW        = 33,
  parameter int unsigned PKT_WORDS = 47,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH*DW-1:0]       ch_din,
  input  logic [NCH-1:0]          ch_din_en,
  input  logic                    out_afull,
  output logic [NCH-1:0]          ch_grant,
  output logic [DW-1:0]           dout,
  output logic                    dout_en,
  output logic [$clog2(NCH)-1:0]  cur_ch,
  output logic                    to_err,
  output logic                    sop_err
);

  localparam int unsigned CHW  = $clog2(NCH);
  localparam int unsigned CNTW = $clog2(PKT_WORDS + 1);
  localparam int unsigned TOW  = $clog2(TIMEOUT + 1);

`ifdef TS_NULL_FILL_EN
  localparam logic [DW-1:0] NULL_SOP  = {1'b1, 32'h471F_FF10};
  localparam logic [DW-1:0] NULL_FILL = {1'b0, 32'hFFFF_FFFF};
  typedef enum logic [1:0] {IDLE, XFER, NULLF} state_t;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif

  state_t            state_q;
  logic [NCH-1:0]    grant_q;
  logic [DW-1:0]     dout_q;
  logic              dout_en_q;
  logic [CHW-1:0]    cur_ch_q;
  logic [CHW-1:0]    last_q;
  logic [CNTW-1:0]   cnt_q;
  logic [TOW-1:0]    idle_q;
  logic              to_err_q;
  logic              sop_err_q;
`ifdef TS_NULL_FILL_EN
  logic [3:0]        nf_q;
`endif

  logic [DW-1:0]     din_arr [NCH];
  logic [DW-1:0]     cur_word;
  logic              cur_en;
  logic              win_found;
  logic [CHW-1:0]    win_idx;
  logic [CHW:0]      idx;
  logic [NCH-1:0]    gnt_d;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign din_arr[g] = ch_din[g*DW +: DW];
  end

  assign cur_word = din_arr[cur_ch_q];
  assign cur_en   = ch_din_en[cur_ch_q];

  // Search last+1, last+2, ... wrapping at NCH; first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = {1'b0, last_q} + (CHW+1)'(k);
      if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
      if (!win_found && ch_req[idx[CHW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[CHW-1:0];
      end
    end
  end

  always_comb begin
    gnt_d          = '0;
    gnt_d[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      cur_ch_q  <= '0;
      last_q    <= CHW'(NCH - 1);
      cnt_q     <= '0;
      idle_q    <= '0;
      to_err_q  <= 1'b0;
      sop_err_q <= 1'b0;
`ifdef TS_NULL_FILL_EN
      nf_q      <= '0;
`endif
    end else begin
      dout_en_q <= 1'b0;
      to_err_q  <= 1'b0;
      sop_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found && !out_afull) begin
            state_q  <= XFER;
            grant_q  <= gnt_d;
            cur_ch_q <= win_idx;
            last_q   <= win_idx;
            cnt_q    <= '0;
            idle_q   <= '0;
`ifdef TS_NULL_FILL_EN
            nf_q     <= '0;
          end else if (!win_found && !out_afull) begin
            // The 16th quiet cycle emits the null SOP word directly.
            if (nf_q == 4'd15) begin
              state_q   <= NULLF;
              dout_q    <= NULL_SOP;
              dout_en_q <= 1'b1;
              cnt_q     <= CNTW'(1);
              nf_q      <= '0;
            end else begin
              nf_q <= nf_q + 4'd1;
            end
          end else begin
            nf_q <= '0;
`endif
          end
        end
        XFER: begin
          if (cur_en) begin
            idle_q <= '0;
            if (cnt_q == '0 && !cur_word[DW-1]) begin
              sop_err_q <= 1'b1;
              grant_q   <= '0;
              state_q   <= IDLE;
            end else begin
              dout_q    <= cur_word;
              dout_en_q <= 1'b1;
              cnt_q     <= cnt_q + CNTW'(1);
              if (cnt_q == CNTW'(PKT_WORDS - 1)) begin
                grant_q <= '0;
                state_q <= IDLE;
              end
            end
          end else if (idle_q == TOW'(TIMEOUT - 1)) begin
            to_err_q <= 1'b1;
            grant_q  <= '0;
            state_q  <= IDLE;
          end else begin
            idle_q <= idle_q + TOW'(1);
          end
        end
`ifdef TS_NULL_FILL_EN
        NULLF: begin
          dout_q    <= NULL_FILL;
          dout_en_q <= 1'b1;
          cnt_q     <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(PKT_WORDS - 1)) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_grant = grant_q;
  assign dout     = dout_q;
  assign dout_en  = dout_en_q;
  assign cur_ch   = cur_ch_q;
  assign to_err   = to_err_q;
  assign sop_err  = sop_err_q;

endmodule
